// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction fetch stage.
// Holds the fetch PC, requests the icache, buffers {pc, inst, pred} in a
// DEPTH-entry FIFO and presents the head entry to the decoder (valid/ready).
// ROB redirect beats decoder redirect; either one flushes the FIFO.
// Optional macro FETCH_BHT_EN: adds a 2-bit-counter branch history table.
// Without it, prediction is static not-taken and br_update_* are ignored.
module fetch_queue_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0,
   parameter int          DEPTH       = 4,
   parameter int          BHT_ENTRIES = 64
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       rob_redirect_valid,
   input  logic [31:0]                rob_redirect_pc,
   input  logic                       dec_redirect_valid,
   input  logic [31:0]                dec_redirect_pc,
   input  logic                       br_update_valid,
   input  logic [31:0]                br_update_pc,
   input  logic                       br_update_taken,
   output logic [31:0]                icache_req_pc,
   input  logic [31:0]                icache_inst,
   input  logic                       icache_hit,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_inst,
   output logic [31:0]                out_pc,
   output logic                       out_pred_taken,
   output logic [$clog2(DEPTH):0]     queue_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   pc_mem_q   [DEPTH];
   logic [31:0]   pc_mem_d   [DEPTH];
   logic [31:0]   inst_mem_q [DEPTH];
   logic [31:0]   inst_mem_d [DEPTH];
   logic          pred_mem_q [DEPTH];
   logic          pred_mem_d [DEPTH];

   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          push;
   logic          pop;
   logic          pred;

   assign redirect    = rob_redirect_valid | dec_redirect_valid;
   assign redirect_pc = rob_redirect_valid ? rob_redirect_pc : dec_redirect_pc;
   // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
   assign push        = !redirect && icache_hit && (count_q < DEPTH_C);
   assign pop         = !redirect && out_valid && out_ready;

`ifdef FETCH_BHT_EN
   localparam int BI = $clog2(BHT_ENTRIES);

   logic [1:0]    bht_q [BHT_ENTRIES];
   logic [1:0]    bht_d [BHT_ENTRIES];
   logic [BI-1:0] look_idx;
   logic [BI-1:0] upd_idx;
   logic          unused_br_bits;

   assign look_idx       = fetch_pc_q[BI+1:2];
   assign upd_idx        = br_update_pc[BI+1:2];
   assign unused_br_bits = ^{br_update_pc[31:BI+2], br_update_pc[1:0]};
   // Lookup reads the registered table, so a same-cycle update is not visible yet.
   assign pred           = bht_q[look_idx][1];

   // Saturating counter update from committed branches, independent of stalls/redirects.
   always_comb begin
      bht_d = bht_q;
      if (br_update_valid) begin
         if (br_update_taken && (bht_q[upd_idx] != 2'b11))
            bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
         else if (!br_update_taken && (bht_q[upd_idx] != 2'b00))
            bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
      end
   end

   // BHT storage; counters start weakly not-taken.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      end else begin
         bht_q <= bht_d;
      end
   end
`else
   logic unused_br;

   assign unused_br = ^{br_update_valid, br_update_pc, br_update_taken};
   assign pred      = 1'b0;
`endif

   // Next fetch PC, FIFO pointers, occupancy and entry writes.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      pc_mem_d   = pc_mem_q;
      inst_mem_d = inst_mem_q;
      pred_mem_d = pred_mem_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            pc_mem_d[wr_ptr_q]   = fetch_pc_q;
            inst_mem_d[wr_ptr_q] = icache_inst;
            pred_mem_d[wr_ptr_q] = pred;
            wr_ptr_d             = wr_ptr_q + PW'(1);
            fetch_pc_d           = fetch_pc_q + 32'd4;
         end
         if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Fetch state and FIFO registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]   <= '0;
            inst_mem_q[i] <= '0;
            pred_mem_q[i] <= 1'b0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         pc_mem_q   <= pc_mem_d;
         inst_mem_q <= inst_mem_d;
         pred_mem_q <= pred_mem_d;
      end
   end

   assign icache_req_pc  = fetch_pc_q;
   assign out_valid      = (count_q != '0);
   assign out_pc         = pc_mem_q[rd_ptr_q];
   assign out_inst       = inst_mem_q[rd_ptr_q];
   assign out_pred_taken = pred_mem_q[rd_ptr_q];
   assign queue_count    = count_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Testbench for fetch_queue_unit: reference model of fetch PC, FIFO and BHT;
// expected entries are queued when pushed and compared when the decoder takes them.
module tb_fetch_queue_unit;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rob_redirect_valid = 1'b0;
   logic [31:0] rob_redirect_pc = '0;
   logic        dec_redirect_valid = 1'b0;
   logic [31:0] dec_redirect_pc = '0;
   logic        br_update_valid = 1'b0;
   logic [31:0] br_update_pc = '0;
   logic        br_update_taken = 1'b0;
   logic [31:0] icache_req_pc;
   logic [31:0] icache_inst = '0;
   logic        icache_hit = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_pred_taken;
   logic [2:0]  queue_count;

   fetch_queue_unit dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .rob_redirect_valid(rob_redirect_valid), .rob_redirect_pc(rob_redirect_pc),
      .dec_redirect_valid(dec_redirect_valid), .dec_redirect_pc(dec_redirect_pc),
      .br_update_valid(br_update_valid), .br_update_pc(br_update_pc),
      .br_update_taken(br_update_taken),
      .icache_req_pc(icache_req_pc), .icache_inst(icache_inst), .icache_hit(icache_hit),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
      .out_pred_taken(out_pred_taken), .queue_count(queue_count)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pred;
   } ent_t;

   ent_t        sb[$];
   logic [31:0] model_pc;
   logic [1:0]  bht_m [64];
   int          vectors = 0;
   int          errors  = 0;

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic model_pred(input logic [31:0] pc);
`ifdef FETCH_BHT_EN
      return bht_m[pc[7:2]][1];
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      sb.delete();
      model_pc = 32'h0;
      for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
   endtask

   // One cycle, entered and left at a falling edge: check outputs, drive, clock, update model.
   task automatic step(input logic hit, input logic ready,
                       input logic rv, input logic [31:0] rpc,
                       input logic dv, input logic [31:0] dpc,
                       input logic bv, input logic [31:0] bpc, input logic bt);
      logic redirect, push, pop, pr;
      ent_t e;
      vectors++;
      if (icache_req_pc !== model_pc) begin
         $display("FAIL req_pc actual=%h required=%h", icache_req_pc, model_pc); errors++;
      end
      vectors++;
      if (queue_count !== 3'(sb.size())) begin
         $display("FAIL count actual=%0d required=%0d", queue_count, sb.size()); errors++;
      end
      vectors++;
      if (out_valid !== (sb.size() != 0)) begin
         $display("FAIL out_valid actual=%b required=%b", out_valid, sb.size() != 0); errors++;
      end
      if (sb.size() != 0) begin
         vectors++;
         if ({out_pc, out_inst, out_pred_taken} !== sb[0]) begin
            $display("FAIL head actual=%h/%h/%b required=%h/%h/%b", out_pc, out_inst,
                     out_pred_taken, sb[0].pc, sb[0].inst, sb[0].pred);
            errors++;
         end
      end
      redirect = rv | dv;
      push = !redirect && hit && (sb.size() < 4);
      pop  = !redirect && ready && (sb.size() != 0);
      pr   = model_pred(model_pc);
      icache_hit = hit; out_ready = ready; icache_inst = inst_of(model_pc);
      rob_redirect_valid = rv; rob_redirect_pc = rpc;
      dec_redirect_valid = dv; dec_redirect_pc = dpc;
      br_update_valid = bv; br_update_pc = bpc; br_update_taken = bt;
      @(posedge clk_in);
      #1;
      icache_hit = 1'b0; out_ready = 1'b0;
      rob_redirect_valid = 1'b0; dec_redirect_valid = 1'b0; br_update_valid = 1'b0;
      if (redirect) begin
         sb.delete();
         model_pc = rv ? rpc : dpc;
      end else begin
         if (pop) void'(sb.pop_front());
         if (push) begin
            e.pc = model_pc; e.inst = inst_of(model_pc); e.pred = pr;
            sb.push_back(e);
            model_pc = model_pc + 32'd4;
         end
      end
      if (bv) begin
         if (bt && bht_m[bpc[7:2]] != 2'b11) bht_m[bpc[7:2]] = bht_m[bpc[7:2]] + 2'b01;
         else if (!bt && bht_m[bpc[7:2]] != 2'b00) bht_m[bpc[7:2]] = bht_m[bpc[7:2]] - 2'b01;
      end
      @(negedge clk_in);
   endtask

   task automatic idle(input logic hit, input logic ready);
      step(hit, ready, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic redir(input logic [31:0] pc);
      step(1'b1, 1'b1, 1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_reset();
      model_reset();
      rst_in = 1'b1;
      @(negedge clk_in); @(negedge clk_in);
      vectors++;
      if ({out_valid, queue_count, icache_req_pc} !== {1'b0, 3'd0, 32'h0}) begin
         $display("FAIL reset_state actual=%b/%0d/%h required=0/0/0", out_valid, queue_count,
                  icache_req_pc);
         errors++;
      end
      vectors++;
      if ({out_pc, out_inst, out_pred_taken} !== 65'h0) begin
         $display("FAIL reset_outs actual=%h/%h/%b required=0", out_pc, out_inst, out_pred_taken);
         errors++;
      end
      rst_in = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_fill();
      for (int i = 0; i < 6; i++) idle(1'b1, 1'b0);
      vectors++;
      if ({queue_count, icache_req_pc} !== {3'd4, 32'h10}) begin
         $display("FAIL fill actual=%0d/%h required=4/00000010", queue_count, icache_req_pc);
         errors++;
      end
   endtask

   task automatic test_pop_full();
      idle(1'b1, 1'b1);
      vectors++;
      if (queue_count !== 3'd3) begin
         $display("FAIL pop_full actual=%0d required=3", queue_count); errors++;
      end
      idle(1'b1, 1'b0);
      vectors++;
      if (queue_count !== 3'd4) begin
         $display("FAIL refill actual=%0d required=4", queue_count); errors++;
      end
   endtask

   task automatic test_redirect();
      step(1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
      vectors++;
      if ({queue_count, icache_req_pc} !== {3'd0, 32'h100}) begin
         $display("FAIL redirect actual=%0d/%h required=0/00000100", queue_count, icache_req_pc);
         errors++;
      end
      idle(1'b1, 1'b0);
      vectors++;
      if ({out_valid, out_pc} !== {1'b1, 32'h100}) begin
         $display("FAIL redirect_head actual=%b/%h required=1/00000100", out_valid, out_pc);
         errors++;
      end
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
      idle(1'b1, 1'b1);
      idle(1'b1, 1'b1);
   endtask

   task automatic test_hit_toggle();
      step(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b0, 1'b0);
      idle(1'b1, 1'b0);
      vectors++;
      if ({queue_count, icache_req_pc} !== {3'd2, 32'h308}) begin
         $display("FAIL hit_toggle actual=%0d/%h required=2/00000308", queue_count, icache_req_pc);
         errors++;
      end
      for (int i = 0; i < 3; i++) idle(1'b0, 1'b1);
      for (int i = 0; i < 8; i++) idle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic test_bht();
`ifdef FETCH_BHT_EN
      redir(32'h1000);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1);
      redir(32'h40);
      idle(1'b1, 1'b0);
      vectors++;
      if (out_pred_taken !== 1'b1) begin
         $display("FAIL bht_taken actual=%b required=1", out_pred_taken); errors++;
      end
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0);
      redir(32'h40);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1);
      vectors++;
      if (out_pred_taken !== 1'b0) begin
         $display("FAIL bht_same_cycle actual=%b required=0", out_pred_taken); errors++;
      end
      redir(32'h40);
      idle(1'b1, 1'b1);
`endif
   endtask

   task automatic test_wrap_and_async_reset();
      redir(32'hFFFF_FFFC);
      idle(1'b1, 1'b0);
      vectors++;
      if (icache_req_pc !== 32'h0) begin
         $display("FAIL pc_wrap actual=%h required=00000000", icache_req_pc); errors++;
      end
      idle(1'b1, 1'b0);
      @(posedge clk_in);
      #2 rst_in = 1'b1;
      #1;
      vectors++;
      if ({out_valid, queue_count, out_pc} !== {1'b0, 3'd0, 32'h0}) begin
         $display("FAIL async_reset actual=%b/%0d/%h required=0/0/0", out_valid, queue_count, out_pc);
         errors++;
      end
      model_reset();
      @(negedge clk_in);
      rst_in = 1'b0;
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b1);
      redir(32'h40);
      idle(1'b1, 1'b0);
      vectors++;
      if ({out_pc, out_pred_taken} !== {32'h40, 1'b0}) begin
         $display("FAIL post_reset_pred actual=%h/%b required=00000040/0", out_pc, out_pred_taken);
         errors++;
      end
      idle(1'b0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_fill();
      test_pop_full();
      test_redirect();
      test_hit_toggle();
      test_bht();
      test_wrap_and_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
